// File: rtl/pg_prefix_resolve_if.sv
`default_nettype none
// ============================================================================
// Module   : pg_prefix_resolve_if
// Purpose  : Pi/Gi input beat and resolved-sum output handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
interface pg_prefix_resolve_if #(
  parameter int WIDTH = 65
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pi;
  logic [WIDTH-1:0] gi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             err;

  modport master (
    output in_valid, pi, gi, out_ready,
    input  in_ready, out_valid, sum, err
  );

  modport slave (
    input  in_valid, pi, gi, out_ready,
    output in_ready, out_valid, sum, err
  );
endinterface
`default_nettype wire

// File: rtl/pg_prefix_resolve.sv
`default_nettype none
// ============================================================================
// Module   : pg_prefix_resolve
// Purpose  : Pipelined Kogge-Stone carry resolver producing sum = pi ^ carries
//            behind a global-stall valid/ready pipeline.
// Options  : define PGR_CHECK_EN to flag beats with any pi & gi bit set.
// Revision : 1.0  initial release
// ============================================================================
module pg_prefix_resolve #(
  parameter int WIDTH            = 65,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pg_prefix_resolve_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);

  logic             w_adv;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;

  logic [WIDTH-1:0] w_g  [LEVELS+1];
  logic [WIDTH-1:0] w_p  [LEVELS];
  logic [WIDTH-1:0] w_pi [LEVELS+1];
  logic             w_v  [LEVELS+1];

  assign w_adv        = ~(r_out_valid & ~bus.out_ready);
  assign bus.in_ready = w_adv;

  // Input rank
  logic [WIDTH-1:0] r_pi0;
  logic [WIDTH-1:0] r_gi0;
  logic             r_v0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_v0 <= 1'b0;
    else if (w_adv) r_v0 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_pi0 <= bus.pi;
      r_gi0 <= bus.gi;
    end
  end

  assign w_g[0]  = r_gi0;
  assign w_p[0]  = r_pi0;
  assign w_pi[0] = r_pi0;
  assign w_v[0]  = r_v0;

`ifdef PGR_CHECK_EN
  logic w_bad [LEVELS+1];
  logic r_bad0;
  always_ff @(posedge clk) begin
    if (w_adv) r_bad0 <= |(bus.pi & bus.gi);
  end
  assign w_bad[0] = r_bad0;
`endif

  // The final level is always registered so the output rank only adds the XOR.
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int D         = 1 << l;
    localparam bit REG_AFTER = ((l + 1) % LEVELS_PER_STAGE == 0) || (l >= LEVELS - 2);

    logic [WIDTH-1:0] w_gn;
    assign w_gn = w_g[l] | (w_p[l] & (w_g[l] << D));

    if (l < LEVELS - 1) begin : g_prop
      logic [WIDTH-1:0] w_pn;
      assign w_pn = w_p[l] & ((w_p[l] << D) | {{(WIDTH-D){1'b0}}, {D{1'b1}}});
      if (REG_AFTER) begin : g_preg
        logic [WIDTH-1:0] r_p;
        always_ff @(posedge clk) begin
          if (w_adv) r_p <= w_pn;
        end
        assign w_p[l+1] = r_p;
      end else begin : g_pwire
        assign w_p[l+1] = w_pn;
      end
    end

    if (REG_AFTER) begin : g_reg
      logic [WIDTH-1:0] r_g;
      logic [WIDTH-1:0] r_pi;
      logic             r_v;
      always_ff @(posedge clk) begin
        if (!rst_n) r_v <= 1'b0;
        else if (w_adv) r_v <= w_v[l];
      end
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_g  <= w_gn;
          r_pi <= w_pi[l];
        end
      end
      assign w_g[l+1]  = r_g;
      assign w_pi[l+1] = r_pi;
      assign w_v[l+1]  = r_v;
`ifdef PGR_CHECK_EN
      logic r_bad;
      always_ff @(posedge clk) begin
        if (w_adv) r_bad <= w_bad[l];
      end
      assign w_bad[l+1] = r_bad;
`endif
    end else begin : g_wire
      assign w_g[l+1]  = w_gn;
      assign w_pi[l+1] = w_pi[l];
      assign w_v[l+1]  = w_v[l];
`ifdef PGR_CHECK_EN
      assign w_bad[l+1] = w_bad[l];
`endif
    end
  end

  // Group generate of the top bit would be the carry out, which has no home.
  logic w_unused_cout;
  assign w_unused_cout = w_g[LEVELS][WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_v[LEVELS];
      r_sum       <= w_pi[LEVELS] ^ {w_g[LEVELS][WIDTH-2:0], 1'b0};
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;

`ifdef PGR_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_adv) r_err <= w_bad[LEVELS];
  end
  assign bus.err = r_out_valid & r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule
`default_nettype wire
